memory_stage: RTL

//   Pipeline stage directly downstream of the execute register. Consumes the ED_* bundle, runs

---
 rtl/memory_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues loads/stores on a req/gnt/rvalid port, aligns load data, registers the MM bundle.
// Optional feature macro MEM_MISALIGN_CHECK_EN: misaligned half/word accesses skip memory and flag MM_misalign_o.
module memory_stage #(
    parameter int XLEN        = 32,
    parameter int PC_WIDTH    = 32,
    parameter int LOAD_WIDTH  = 5,
    parameter int STORE_WIDTH = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   execute_vaild_i,
    input  logic [LOAD_WIDTH-1:0]  ED_load_op_i,
    input  logic [STORE_WIDTH-1:0] ED_store_op_i,
    input  logic [XLEN-1:0]        ED_valE_i,
    input  logic [XLEN-1:0]        ED_rs2_data_i,
    input  logic                   ED_need_dstE_i,
    input  logic [4:0]             ED_dstE_i,
    input  logic [PC_WIDTH-1:0]    ED_PC_i,
    input  logic                   ED_commit_i,
    input  logic                   writeback_allow_in_i,
    output logic                   memory_allow_in_o,
    output logic                   dmem_req_o,
    output logic                   dmem_we_o,
    output logic [XLEN-1:0]        dmem_addr_o,
    output logic [XLEN-1:0]        dmem_wdata_o,
    output logic [3:0]             dmem_wstrb_o,
    input  logic                   dmem_gnt_i,
    input  logic                   dmem_rvalid_i,
    input  logic [XLEN-1:0]        dmem_rdata_i,
    output logic                   memory_vaild_o,
    output logic [XLEN-1:0]        MM_valM_o,
    output logic                   MM_need_dstE_o,
    output logic [4:0]             MM_dstE_o,
    output logic [PC_WIDTH-1:0]    MM_PC_o,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic                   MM_misalign_o,
`endif
    output logic                   MM_commit_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
    state_t r_state, w_next;

    logic [LOAD_WIDTH-1:0]  r_load_op;
    logic [STORE_WIDTH-1:0] r_store_op;
    logic [XLEN-1:0]        r_addr, r_wdata, r_hold_val;
    logic                   r_need, r_commit;
    logic [4:0]             r_dst;
    logic [PC_WIDTH-1:0]    r_pc;

    logic                   r_mm_vld, r_mm_need, r_mm_commit;
    logic [XLEN-1:0]        r_mm_valM;
    logic [4:0]             r_mm_dst;
    logic [PC_WIDTH-1:0]    r_mm_pc;

    logic w_mm_free, w_accept, w_ed_mem, w_ed_mis, w_ed_go, w_is_store, w_done;
    logic [7:0]      w_lbyte;
    logic [15:0]     w_lhalf;
    logic [XLEN-1:0] w_load_val, w_res_val, w_st_data;
    logic [3:0]      w_st_strb;

    assign w_mm_free  = ~r_mm_vld | writeback_allow_in_i;
    assign w_accept   = execute_vaild_i & memory_allow_in_o;
    assign w_ed_mem   = (|ED_load_op_i) | (|ED_store_op_i);
`ifdef MEM_MISALIGN_CHECK_EN
    assign w_ed_mis   = ((ED_load_op_i[1] | ED_load_op_i[4] | ED_store_op_i[1]) & ED_valE_i[0])
                      | ((ED_load_op_i[2] | ED_store_op_i[2]) & (|ED_valE_i[1:0]));
`else
    assign w_ed_mis   = 1'b0;
`endif
    assign w_ed_go    = w_ed_mem & ~w_ed_mis;
    assign w_is_store = |r_store_op;
    assign w_done     = ((r_state == S_REQ) & dmem_gnt_i & w_is_store)
                      | ((r_state == S_WAIT) & dmem_rvalid_i);

    always_ff @(posedge clk_i) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_ed_go) w_next = S_REQ;
            S_REQ:   if (dmem_gnt_i) w_next = !w_is_store ? S_WAIT : (w_mm_free ? S_IDLE : S_HOLD);
            S_WAIT:  if (dmem_rvalid_i) w_next = w_mm_free ? S_IDLE : S_HOLD;
            S_HOLD:  if (w_mm_free) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Port fields are zero outside REQ so the bus is quiet while idle or after reset.
    always_comb begin
        memory_allow_in_o = rst_n & (r_state == S_IDLE) & w_mm_free;
        dmem_req_o        = (r_state == S_REQ);
        dmem_we_o         = dmem_req_o & w_is_store;
        dmem_addr_o       = dmem_req_o ? {r_addr[XLEN-1:2], 2'b00} : '0;
        dmem_wdata_o      = dmem_we_o ? w_st_data : '0;
        dmem_wstrb_o      = dmem_we_o ? w_st_strb : 4'b0000;
    end

    always_comb begin
        w_st_strb = 4'b0000;
        w_st_data = '0;
        if (r_store_op[0]) begin
            w_st_strb = 4'b0001 << r_addr[1:0];
            w_st_data = {4{r_wdata[7:0]}};
        end else if (r_store_op[1]) begin
            w_st_strb = 4'b0011 << {r_addr[1], 1'b0};
            w_st_data = {2{r_wdata[15:0]}};
        end else if (r_store_op[2]) begin
            w_st_strb = 4'b1111;
            w_st_data = r_wdata;
        end
    end

    assign w_lbyte = dmem_rdata_i[{r_addr[1:0], 3'b000} +: 8];
    assign w_lhalf = dmem_rdata_i[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load_val = '0;
        if      (r_load_op[0]) w_load_val = {{(XLEN-8){w_lbyte[7]}}, w_lbyte};
        else if (r_load_op[1]) w_load_val = {{(XLEN-16){w_lhalf[15]}}, w_lhalf};
        else if (r_load_op[2]) w_load_val = dmem_rdata_i;
        else if (r_load_op[3]) w_load_val = {{(XLEN-8){1'b0}}, w_lbyte};
        else if (r_load_op[4]) w_load_val = {{(XLEN-16){1'b0}}, w_lhalf};
    end

    assign w_res_val = w_is_store ? r_addr : w_load_val;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_load_op <= '0;  r_store_op <= '0;  r_addr <= '0;  r_wdata <= '0;
            r_need <= 1'b0;   r_dst <= '0;       r_pc <= '0;    r_commit <= 1'b0;
            r_hold_val <= '0;
            r_mm_vld <= 1'b0; r_mm_valM <= '0;   r_mm_need <= 1'b0;
            r_mm_dst <= '0;   r_mm_pc <= '0;     r_mm_commit <= 1'b0;
        end else begin
            if (w_accept) begin
                r_load_op <= ED_load_op_i;  r_store_op <= ED_store_op_i;
                r_addr    <= ED_valE_i;     r_wdata    <= ED_rs2_data_i;
                r_need    <= ED_need_dstE_i; r_dst     <= ED_dstE_i;
                r_pc      <= ED_PC_i;       r_commit   <= ED_commit_i;
            end
            if (w_done) r_hold_val <= w_res_val;
            // A memory-op accept falls to the last branch: MM drains and a bubble follows.
            if (w_accept && !w_ed_go) begin
                r_mm_vld  <= 1'b1;               r_mm_valM   <= ED_valE_i;
                r_mm_need <= ED_need_dstE_i & ~w_ed_mis;
                r_mm_dst  <= ED_dstE_i;          r_mm_pc     <= ED_PC_i;
                r_mm_commit <= ED_commit_i;
            end else if ((w_done || r_state == S_HOLD) && w_mm_free) begin
                r_mm_vld  <= 1'b1;
                r_mm_valM <= (r_state == S_HOLD) ? r_hold_val : w_res_val;
                r_mm_need <= r_need;  r_mm_dst <= r_dst;
                r_mm_pc   <= r_pc;    r_mm_commit <= r_commit;
            end else if (w_mm_free) begin
                r_mm_vld  <= 1'b0;    r_mm_valM <= '0;  r_mm_need <= 1'b0;
                r_mm_dst  <= '0;      r_mm_pc   <= '0;  r_mm_commit <= 1'b0;
            end
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic r_mm_mis;
    always_ff @(posedge clk_i) begin
        if (!rst_n)                    r_mm_mis <= 1'b0;
        else if (w_accept && !w_ed_go) r_mm_mis <= w_ed_mis;
        else if (w_mm_free)            r_mm_mis <= 1'b0;
    end
    assign MM_misalign_o = r_mm_mis;
`endif

    assign memory_vaild_o = r_mm_vld;
    assign MM_valM_o      = r_mm_valM;
    assign MM_need_dstE_o = r_mm_need;
    assign MM_dstE_o      = r_mm_dst;
    assign MM_PC_o        = r_mm_pc;
    assign MM_commit_o    = r_mm_commit;
endmodule
